// File: rtl/shift_pkg.sv
// Shared types and helpers for the universal shift register.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5,
        OP_ASR  = 3'd6
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op >= 3'd2) && (op <= 3'd6);
    endfunction

endpackage

// File: rtl/shift_unit.sv
// Combinational next value and shifted-out bit for one operation.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
    output logic [WIDTH-1:0] nxt,
    output logic             out_bit,
    output logic             out_upd
);

    always_comb begin
        nxt     = d;
        out_bit = 1'b0;
        out_upd = 1'b0;
        case (op)
            OP_LOAD: nxt = load_data;
            OP_SHL: begin
                nxt     = {d[WIDTH-2:0], ser_in};
                out_bit = d[WIDTH-1];
                out_upd = 1'b1;
            end
            OP_SHR: begin
                nxt     = {ser_in, d[WIDTH-1:1]};
                out_bit = d[0];
                out_upd = 1'b1;
            end
            OP_ROL: begin
                nxt     = {d[WIDTH-2:0], d[WIDTH-1]};
                out_bit = d[WIDTH-1];
                out_upd = 1'b1;
            end
            OP_ROR: begin
                nxt     = {d[0], d[WIDTH-1:1]};
                out_bit = d[0];
                out_upd = 1'b1;
            end
            OP_ASR: begin
                nxt     = {d[WIDTH-1], d[WIDTH-1:1]};
                out_bit = d[0];
                out_upd = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register with direct ops and an autonomous N-shift burst engine.
module shift_reg_univ
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               ser_q, ser_d;
    logic               done_q, done_d;

    logic [2:0]         unit_op;
    logic [WIDTH-1:0]   unit_nxt;
    logic               unit_bit;
    logic               unit_upd;

    // During a burst the latched op drives the datapath; live op is ignored.
    assign unit_op = (state_q == ST_RUN) ? op_q : op;

    shift_unit #(.WIDTH(WIDTH)) u_shift_unit (
        .d         (data_q),
        .op        (unit_op),
        .load_data (load_data),
        .ser_in    (ser_in),
        .nxt       (unit_nxt),
        .out_bit   (unit_bit),
        .out_upd   (unit_upd)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ser_d   = ser_q;
        done_d  = 1'b0;
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (start && is_shift_op(op)) begin
                        op_d  = op_e'(op);
                        cnt_d = burst_len;
                        if (burst_len != '0) state_d = ST_RUN;
                        else                 done_d  = 1'b1;
                    end else begin
                        data_d = unit_nxt;
                        if (unit_upd) ser_d = unit_bit;
                    end
                end
                ST_RUN: begin
                    data_d = unit_nxt;
                    if (unit_upd) ser_d = unit_bit;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            data_q  <= '0;
            ser_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
        end
    end

    assign data_out = data_q;
    assign ser_out  = ser_q;
    assign busy     = (state_q == ST_RUN);
    assign done     = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ with an arithmetic reference model.
module tb_shift_reg_univ;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             en;
    logic [2:0]       op;
    logic [WIDTH-1:0] load_data;
    logic             ser_in;
    logic             start;
    logic [CNT_W-1:0] burst_len;
    logic [WIDTH-1:0] data_out;
    logic             ser_out;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_data, m_ser, m_rem, m_bop, m_done;

    shift_reg_univ #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .op        (op),
        .load_data (load_data),
        .ser_in    (ser_in),
        .start     (start),
        .burst_len (burst_len),
        .data_out  (data_out),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_in = ~clk_in;

    task automatic m_reset();
        m_data = 0; m_ser = 0; m_rem = 0; m_bop = 0; m_done = 0;
    endtask

    // Apply one operation to the model using plain arithmetic on the value.
    task automatic m_apply(input int o);
        int d;
        d = m_data;
        case (o)
            1: m_data = int'(load_data);
            2: begin m_data = (d * 2) % 256 + int'(ser_in); m_ser = d / 128; end
            3: begin m_data = d / 2 + 128 * int'(ser_in);   m_ser = d % 2;   end
            4: begin m_data = (d * 2) % 256 + d / 128;       m_ser = d / 128; end
            5: begin m_data = d / 2 + 128 * (d % 2);         m_ser = d % 2;   end
            6: begin m_data = d / 2 + ((d >= 128) ? 128 : 0); m_ser = d % 2; end
            default: ;
        endcase
    endtask

    task automatic model_step();
        int nd;
        nd = 0;
        if (en) begin
            if (m_rem > 0) begin
                m_apply(m_bop);
                m_rem--;
                if (m_rem == 0) nd = 1;
            end else if (start && op >= 2 && op <= 6) begin
                m_bop = int'(op);
                m_rem = int'(burst_len);
                if (m_rem == 0) nd = 1;
            end else begin
                m_apply(int'(op));
            end
        end
        m_done = nd;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_in(input logic e, input logic [2:0] o, input logic [7:0] ld,
                          input logic si, input logic st, input logic [3:0] bl);
        en = e; op = o; load_data = ld; ser_in = si; start = st; burst_len = bl;
    endtask

    task automatic test_reset();
        set_in(0, 0, 8'h00, 0, 0, 4'd0);
        rst_n = 1'b0;
        m_reset();
        @(posedge clk_in); #1;
        n_checks++;
        if ({data_out, ser_out, busy, done} !== 11'b0) begin
            n_errors++;
            $display("FAIL reset_state: got data=%h ser=%b busy=%b done=%b, want all 0",
                     data_out, ser_out, busy, done);
        end
        rst_n = 1'b1;
        set_in(1, 3'd1, 8'hA5, 0, 0, 4'd0);
        cyc();
        n_checks++;
        if (data_out !== 8'hA5) begin
            n_errors++;
            $display("FAIL direct_load: got %h want a5", data_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 8'h00) begin
            n_errors++;
            $display("FAIL async_reset: got %h want 00", data_out);
        end
        m_reset();
        set_in(0, 0, 8'h00, 0, 0, 4'd0);
        @(posedge clk_in); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_direct_ops();
        logic [2:0] ops [7]  = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd7};
        logic       sis [7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] want [7] = '{8'h4B, 8'h52, 8'h4B, 8'hD2, 8'hD2, 8'hA5, 8'hA5};
        for (int i = 0; i < 7; i++) begin
            set_in(1, 3'd1, 8'hA5, 0, 0, 4'd0);
            cyc();
            set_in(1, ops[i], 8'h3C, sis[i], 0, 4'd0);
            cyc();
            n_checks++;
            if (data_out !== want[i] || ser_out !== 1'(m_ser) || data_out !== 8'(m_data)) begin
                n_errors++;
                $display("FAIL direct_op%0d: got data=%h ser=%b want data=%h ser=%b",
                         ops[i], data_out, ser_out, want[i], 1'(m_ser));
            end
        end
    endtask

    task automatic test_direct_random();
        for (int i = 0; i < 80; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom),
                   1'($urandom), 0, 4'($urandom));
            cyc();
            n_checks++;
            if ({data_out, ser_out, busy, done} !== {8'(m_data), 1'(m_ser), 1'b0, 1'b0}) begin
                n_errors++;
                $display("FAIL direct_rand[%0d]: got %h/%b/%b/%b want %h/%b/0/0",
                         i, data_out, ser_out, busy, done, 8'(m_data), 1'(m_ser));
            end
        end
    endtask

    task automatic test_burst();
        logic [7:0] want [3] = '{8'h03, 8'h06, 8'h0C};
        set_in(1, 3'd1, 8'h81, 0, 0, 4'd0);
        cyc();
        set_in(1, 3'd4, 8'h00, 0, 1, 4'd3);
        cyc();
        n_checks++;
        if (data_out !== 8'h81 || busy !== 1'b1 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL burst_accept: got data=%h busy=%b done=%b want 81/1/0",
                     data_out, busy, done);
        end
        set_in(1, 3'd0, 8'h00, 0, 0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if (data_out !== want[i] || busy !== (i < 2) || done !== (i == 2)) begin
                n_errors++;
                $display("FAIL burst_step%0d: got data=%h busy=%b done=%b want %h/%b/%b",
                         i, data_out, busy, done, want[i], i < 2, i == 2);
            end
        end
        cyc();
        n_checks++;
        if (done !== 1'b0 || data_out !== 8'h0C) begin
            n_errors++;
            $display("FAIL burst_done_pulse: got done=%b data=%h want 0/0c", done, data_out);
        end
    endtask

    task automatic test_stall_ignore();
        set_in(1, 3'd1, 8'h81, 0, 0, 4'd0);
        cyc();
        set_in(1, 3'd4, 8'h00, 0, 1, 4'd3);
        cyc();
        set_in(1, 3'd1, 8'hFF, 0, 1, 4'd7);
        cyc();
        for (int i = 0; i < 2; i++) begin
            en = 1'b0;
            cyc();
            n_checks++;
            if (data_out !== 8'h03 || busy !== 1'b1 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL stall%0d: got data=%h busy=%b done=%b want 03/1/0",
                         i, data_out, busy, done);
            end
        end
        en = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if (data_out !== 8'h0C || busy !== 1'b0 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_final: got data=%h busy=%b done=%b want 0c/0/1",
                     data_out, busy, done);
        end
        set_in(1, 3'd0, 8'h00, 0, 0, 4'd0);
        cyc();
    endtask

    task automatic test_edges();
        set_in(1, 3'd2, 8'h00, 1, 1, 4'd0);
        cyc();
        n_checks++;
        if (data_out !== 8'h0C || busy !== 1'b0 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL len0: got data=%h busy=%b done=%b want 0c/0/1", data_out, busy, done);
        end
        set_in(1, 3'd1, 8'h5A, 0, 1, 4'd3);
        cyc();
        n_checks++;
        if (data_out !== 8'h5A || busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL start_load: got data=%h busy=%b done=%b want 5a/0/0",
                     data_out, busy, done);
        end
        set_in(1, 3'd5, 8'h00, 0, 1, 4'd1);
        cyc();
        set_in(1, 3'd0, 8'h00, 0, 0, 4'd0);
        cyc();
        n_checks++;
        if (data_out !== 8'h2D || done !== 1'b1 || ser_out !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_first: got data=%h done=%b ser=%b want 2d/1/0",
                     data_out, done, ser_out);
        end
        set_in(1, 3'd6, 8'h00, 0, 1, 4'd2);
        cyc();
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_accept: got busy=%b done=%b want 1/0", busy, done);
        end
        set_in(1, 3'd0, 8'h00, 0, 0, 4'd0);
        cyc();
        cyc();
        n_checks++;
        if (data_out !== 8'h0B || done !== 1'b1 || ser_out !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_second: got data=%h done=%b ser=%b want 0b/1/0",
                     data_out, done, ser_out);
        end
        cyc();
    endtask

    task automatic test_reset_mid_burst();
        set_in(1, 3'd1, 8'h81, 0, 0, 4'd0);
        cyc();
        set_in(1, 3'd4, 8'h00, 0, 1, 4'd3);
        cyc();
        set_in(1, 3'd0, 8'h00, 0, 0, 4'd0);
        cyc();
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        n_checks++;
        if (busy !== 1'b0 || data_out !== 8'h00 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_burst: got busy=%b data=%h done=%b want 0/00/0",
                     busy, data_out, done);
        end
        @(posedge clk_in); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_no_done%0d: got done=%b busy=%b want 0/0", i, done, busy);
            end
        end
    endtask

    task automatic test_random_bursts();
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 4) != 0), 3'($urandom), 8'($urandom), 1'($urandom),
                   1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 10)));
            cyc();
            n_checks++;
            if ({data_out, ser_out, busy, done} !==
                {8'(m_data), 1'(m_ser), m_rem > 0, 1'(m_done)}) begin
                n_errors++;
                $display("FAIL burst_rand[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                         data_out, ser_out, busy, done, 8'(m_data), 1'(m_ser),
                         m_rem > 0, 1'(m_done));
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct_ops();
        test_direct_random();
        test_burst();
        test_stall_ignore();
        test_edges();
        test_reset_mid_burst();
        test_random_bursts();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
Parametrised universal shift register, the next generation of the team's 4-bit left/right serial shifter.
- Adds parallel load, rotate, arithmetic right shift and a registered serial output.
- Adds a burst engine: one start command runs N shifts autonomously, with busy/done status.
- Used as a generic serializer/deserializer and bit-manipulation stage in datapath and peripheral blocks.

Parameters:
WIDTH, 8, register width in bits; legal range 2 and up.
CNT_W, $clog2(WIDTH+1), width of burst_len and of the internal burst counter.

Ports:
clk_in  input  1  clock; all state updates on its rising edge.
rst_n  input  1  reset; asynchronous, active-low.
en  input  1  cycle enable; when low, data_out, ser_out and the burst counter hold.
op  input  3  operation code (encoding in Behaviour).
load_data  input  WIDTH  parallel load value for LOAD.
ser_in  input  1  fill bit for SHL (into LSB) and SHR (into MSB).
start  input  1  burst request; sampled only when busy=0.
burst_len  input  CNT_W  number of shifts in a burst; 0 is legal.
data_out  output  WIDTH  register contents.
ser_out  output  1  registered copy of the bit last shifted or rotated out.
busy  output  1  high while a burst is in progress.
done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (rst_n low, asynchronous): data_out=0, ser_out=0, busy=0, done=0, counter=0, latched op=HOLD.
- op encoding:
  - 0 HOLD.
  - 1 LOAD: data_out<=load_data.
  - 2 SHL: {d[W-2:0],ser_in}.
  - 3 SHR: {ser_in,d[W-1:1]}.
  - 4 ROL: {d[W-2:0],d[W-1]}.
  - 5 ROR: {d[0],d[W-1:1]}.
  - 6 ASR: {d[W-1],d[W-1:1]}.
  - 7: reserved, behaves as HOLD.
- ser_out:
  - SHL and ROL: ser_out<=old d[W-1].
  - SHR, ROR and ASR: ser_out<=old d[0].
  - HOLD, LOAD and 7: ser_out unchanged.
- Direct mode (busy=0, start=0): op executes on every edge with en=1. Latency is 1 cycle. With en=0, nothing changes.
- Burst FSM has states IDLE and RUN.
  - IDLE, start=1, op in {2..6}: the accepting edge latches op, sets cnt<=burst_len and performs no shift.
    - burst_len>0: busy<=1, go to RUN.
    - burst_len=0: stay in IDLE, done<=1.
  - IDLE, start=1, op not in {2..6}: start is ignored and op executes as in direct mode.
  - RUN: each edge with en=1 applies the latched op and decrements cnt.
    - The edge where cnt==1 shifts, then busy<=0, done<=1, and the FSM returns to IDLE.
    - The final value is visible on data_out in the same cycle done is high.
  - RUN, en=0: stall; cnt, data_out and ser_out hold, busy stays 1.
  - RUN: op, start, load_data and burst_len inputs are ignored. ser_in is still sampled live for SHL/SHR.
- done is high for exactly one cycle; it deasserts on the next edge regardless of en.
- Back-to-back bursts: start may be accepted in the cycle done=1, since busy is already 0.
- burst_len > WIDTH is legal; rotates simply wrap further.
- Reset asserted mid-burst aborts immediately to the reset values; no done pulse is produced.

Decomposition:
- Package shift_pkg:
  - op enum: OP_HOLD, OP_LOAD, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR.
  - FSM state enum: ST_IDLE, ST_RUN.
  - Helper function is_shift_op().
- Sub-module shift_unit: combinational next-value and out-bit for a given op, parameterised on WIDTH.
- Top level holds the registers, the FSM and the counter.

Test Plan:
- Reset and direct load (WIDTH=8): LOAD 8'hA5 -> data_out=8'hA5 after 1 edge; assert rst_n low mid-cycle -> data_out=0 immediately (asynchronous).
- Direct ops from 8'hA5, each applied singly:
  - SHL, ser_in=1 -> 8'h4B, ser_out=1.
  - SHR, ser_in=0 -> 8'h52, ser_out=1.
  - ROL -> 8'h4B.
  - ROR -> 8'hD2.
  - ASR -> 8'hD2, ser_out=1.
  - HOLD/op=7 -> unchanged.
- Burst: load 8'h81; start with ROL, burst_len=3, en=1 -> data_out 8'h03, 8'h06, 8'h0C on the 3 edges after accept; busy high for 3 cycles; done=1 for one cycle together with 8'h0C.
- Stall and ignore: same burst with en low for 2 cycles mid-burst, and start/LOAD asserted during busy -> same final 8'h0C, done 2 cycles later, no load occurs.
- Edge cases:
  - burst_len=0 -> no shift, busy stays 0, done pulses on the next cycle.
  - start with op=LOAD -> acts as direct LOAD, no done.
  - Back-to-back burst started in the done cycle -> accepted.
- Reset mid-burst: rst_n low at cnt=2 -> busy=0, data_out=0, and done never pulses.
